// File: rtl/alu_iter_if.sv
// Request/response bundle between an ALU issuer and the iterative ALU.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_iter_if #(
  parameter int XLEN = 32
);
  logic            inValid;
  logic            inReady;
  logic [3:0]      aluControl;
  logic            isBranch;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] aluResult;
  logic            takeBranch;
  logic            zero;

  modport master (
    output inValid, aluControl, isBranch, srcA, srcB, outReady,
    input  inReady, outValid, aluResult, takeBranch, zero
  );

  modport slave (
    input  inValid, aluControl, isBranch, srcA, srcB, outReady,
    output inReady, outValid, aluResult, takeBranch, zero
  );
endinterface

// File: rtl/alu_iter.sv
// Single-issue ALU with branch compare; shifts are performed one bit per clock,
// everything else completes in one cycle. Result is held until the consumer accepts it.
module alu_iter #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       reset,
  alu_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            take_reg, take_next;
  logic            zero_reg, zero_next;
  logic [4:0]      count_reg, count_next;
  logic            shift_left_reg, shift_left_next;
  logic            shift_arith_reg, shift_arith_next;

  logic [XLEN-1:0] sum, diff, op_result;
  logic [XLEN-1:0] shl_step, shr_step, step_out;
  logic            lt_signed, lt_unsigned, op_take, op_shift;
  logic [4:0]      shamt;

  assign sum         = bus.srcA + bus.srcB;
  assign diff        = bus.srcA - bus.srcB;
  assign lt_signed   = $signed(bus.srcA) < $signed(bus.srcB);
  assign lt_unsigned = bus.srcA < bus.srcB;
  assign shamt       = bus.srcB[4:0];
  assign op_shift    = !bus.isBranch &&
                       (bus.aluControl == 4'h2 || bus.aluControl == 4'h6 || bus.aluControl == 4'h7);

  // One-bit shift network applied to the working register each SHIFT cycle.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_step
    if (gi == 0) begin : g_lsb
      assign shl_step[gi] = 1'b0;
    end else begin : g_mid_l
      assign shl_step[gi] = result_reg[gi-1];
    end
    if (gi == XLEN - 1) begin : g_msb
      assign shr_step[gi] = shift_arith_reg & result_reg[gi];
    end else begin : g_mid_r
      assign shr_step[gi] = result_reg[gi+1];
    end
  end

  assign step_out = shift_left_reg ? shl_step : shr_step;

  // Single-cycle operations; unlisted opcode combinations fall back to add.
  always_comb begin
    op_result = sum;
    op_take   = 1'b0;
    if (bus.isBranch) begin
      case (bus.aluControl)
        4'ha: begin op_result = diff; op_take = (bus.srcA == bus.srcB); end
        4'hb: begin op_result = diff; op_take = (bus.srcA != bus.srcB); end
        4'h3: begin op_result = diff; op_take = lt_signed;              end
        4'h4: begin op_result = diff; op_take = lt_unsigned;            end
        4'hc: begin op_result = diff; op_take = !lt_signed;             end
        4'hd: begin op_result = diff; op_take = !lt_unsigned;           end
        default: ;
      endcase
    end else begin
      case (bus.aluControl)
        4'h1:    op_result = diff;
        4'h3:    op_result = {{(XLEN-1){1'b0}}, lt_signed};
        4'h4:    op_result = {{(XLEN-1){1'b0}}, lt_unsigned};
        4'h5:    op_result = bus.srcA ^ bus.srcB;
        4'h8:    op_result = bus.srcA | bus.srcB;
        4'h9:    op_result = bus.srcA & bus.srcB;
        // Shifts reaching here have shamt 0 and pass srcA through.
        4'h2, 4'h6, 4'h7: op_result = bus.srcA;
        default: op_result = sum;
      endcase
    end
  end

  always_comb begin
    state_next       = state_reg;
    result_next      = result_reg;
    take_next        = take_reg;
    zero_next        = zero_reg;
    count_next       = count_reg;
    shift_left_next  = shift_left_reg;
    shift_arith_next = shift_arith_reg;
    case (state_reg)
      IDLE: begin
        if (bus.inValid) begin
          if (op_shift && shamt != 5'd0) begin
            state_next       = SHIFT;
            result_next      = bus.srcA;
            count_next       = shamt;
            take_next        = 1'b0;
            zero_next        = 1'b0;
            shift_left_next  = (bus.aluControl == 4'h2);
            shift_arith_next = (bus.aluControl == 4'h6);
          end else begin
            state_next  = DONE;
            result_next = op_result;
            take_next   = op_take;
            zero_next   = (op_result == '0);
          end
        end
      end
      SHIFT: begin
        result_next = step_out;
        count_next  = count_reg - 5'd1;
        if (count_reg == 5'd1) begin
          state_next = DONE;
          zero_next  = (step_out == '0);
        end
      end
      DONE: begin
        if (bus.outReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      result_reg      <= '0;
      take_reg        <= 1'b0;
      zero_reg        <= 1'b0;
      count_reg       <= 5'd0;
      shift_left_reg  <= 1'b0;
      shift_arith_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      result_reg      <= result_next;
      take_reg        <= take_next;
      zero_reg        <= zero_next;
      count_reg       <= count_next;
      shift_left_reg  <= shift_left_next;
      shift_arith_reg <= shift_arith_next;
    end
  end

  assign bus.inReady    = (state_reg == IDLE);
  assign bus.outValid   = (state_reg == DONE);
  assign bus.aluResult  = result_reg;
  assign bus.takeBranch = take_reg;
  assign bus.zero       = zero_reg;
endmodule

// File: tb/tb_alu_iter.sv
// Randomized and directed bench for alu_iter; expected responses are queued at issue
// and checked by an independent monitor when each result is handed over.
module tb_alu_iter;
  typedef struct packed {
    logic [31:0] r;
    logic        t;
    logic        z;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  alu_iter_if #(.XLEN(32)) bus ();

  alu_iter #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic exp_t model(input logic [3:0] c, input logic br,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.r = a + b;
    e.t = 1'b0;
    if (br) begin
      case (c)
        4'ha: begin e.r = a - b; e.t = (a == b); end
        4'hb: begin e.r = a - b; e.t = (a != b); end
        4'h3: begin e.r = a - b; e.t = ($signed(a) < $signed(b)); end
        4'h4: begin e.r = a - b; e.t = (a < b); end
        4'hc: begin e.r = a - b; e.t = ($signed(a) >= $signed(b)); end
        4'hd: begin e.r = a - b; e.t = (a >= b); end
        default: ;
      endcase
    end else begin
      case (c)
        4'h1: e.r = a - b;
        4'h2: e.r = a << b[4:0];
        4'h3: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'h4: e.r = (a < b) ? 32'd1 : 32'd0;
        4'h5: e.r = a ^ b;
        4'h6: e.r = $signed(a) >>> b[4:0];
        4'h7: e.r = a >> b[4:0];
        4'h8: e.r = a | b;
        4'h9: e.r = a & b;
        default: ;
      endcase
    end
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  function automatic int latency(input logic [3:0] c, input logic br, input logic [31:0] b);
    if (!br && (c == 4'h2 || c == 4'h6 || c == 4'h7) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one operation, measures latency, optionally stalls the consumer, then accepts.
  task automatic do_op(input logic [3:0] c, input logic br, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input exp_t e, input int lat);
    int waitc;
    int cnt;
    logic [31:0] held;
    waitc = 0;
    while (!bus.inReady && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("in_ready_before_issue", {31'd0, bus.inReady}, 32'd1);
    bus.inValid    = 1'b1;
    bus.aluControl = c;
    bus.isBranch   = br;
    bus.srcA       = a;
    bus.srcB       = b;
    exp_q.push_back(e);
    @(negedge clk);
    bus.inValid    = 1'b0;
    bus.srcA       = $urandom;
    bus.srcB       = $urandom;
    bus.aluControl = 4'($urandom);
    bus.isBranch   = 1'($urandom);
    cnt = 1;
    while (!bus.outValid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.outValid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_valid_timeout: got no outValid after %0d cycles required latency %0d", cnt, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      pulse_reset();
      return;
    end
    chk("latency", 32'(cnt), 32'(lat));
    held = bus.aluResult;
    for (int h = 0; h < hold; h++) begin
      bus.inValid = 1'b1;
      bus.srcA    = ~bus.srcA;
      @(negedge clk);
      chk("hold_out_valid", {31'd0, bus.outValid}, 32'd1);
      chk("hold_in_ready", {31'd0, bus.inReady}, 32'd0);
      chk("hold_result", bus.aluResult, held);
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    @(negedge clk);
    bus.outReady = 1'b0;
    chk("idle_after_accept_ready", {31'd0, bus.inReady}, 32'd1);
    chk("idle_after_accept_valid", {31'd0, bus.outValid}, 32'd0);
  endtask

  task automatic rnd_op(input int hold);
    logic [3:0]  c;
    logic        br;
    logic [31:0] a, b;
    c  = 4'($urandom);
    br = 1'($urandom);
    a  = $urandom;
    b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
    if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 0 ? 1'b1 : 1'b0, 31'($urandom)};
    do_op(c, br, a, b, hold, model(c, br, a, b), latency(c, br, b));
  endtask

  // Monitor: one comparison set per completed result handover.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && bus.outValid && bus.outReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got result 0x%08h required no output", bus.aluResult);
        end else begin
          e = exp_q.pop_front();
          chk("result", bus.aluResult, e.r);
          chk("take_branch", {31'd0, bus.takeBranch}, {31'd0, e.t});
          chk("zero", {31'd0, bus.zero}, {31'd0, e.z});
          $display("txn result=0x%08h take=%0d zero=%0d", bus.aluResult, bus.takeBranch, bus.zero);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset          = 1'b1;
    bus.inValid    = 1'b0;
    bus.outReady   = 1'b0;
    bus.aluControl = 4'h0;
    bus.isBranch   = 1'b0;
    bus.srcA       = 32'h0;
    bus.srcB       = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'd0, bus.inReady}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.outValid}, 32'd0);
    chk("reset_result", bus.aluResult, 32'd0);
    chk("reset_take", {31'd0, bus.takeBranch}, 32'd0);
    chk("reset_zero", {31'd0, bus.zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(4'h0, 1'b0, 32'h7FFFFFFF, 32'h1, 0, '{32'h80000000, 1'b0, 1'b0}, 1);
    do_op(4'h1, 1'b0, 32'd5, 32'd5, 0, '{32'h0, 1'b0, 1'b1}, 1);
    do_op(4'h6, 1'b0, 32'h80000010, 32'd4, 0, '{32'hF8000001, 1'b0, 1'b0}, 5);
    do_op(4'h7, 1'b0, 32'h80000010, 32'd4, 0, '{32'h08000001, 1'b0, 1'b0}, 5);
    do_op(4'h2, 1'b0, 32'h12345678, 32'h20, 0, '{32'h12345678, 1'b0, 1'b0}, 1);
    do_op(4'h2, 1'b0, 32'h3, 32'd31, 0, '{32'h80000000, 1'b0, 1'b0}, 32);
    do_op(4'hc, 1'b1, 32'hFFFFFFFF, 32'h1, 0, '{32'hFFFFFFFE, 1'b0, 1'b0}, 1);
    do_op(4'hd, 1'b1, 32'hFFFFFFFF, 32'h1, 0, '{32'hFFFFFFFE, 1'b1, 1'b0}, 1);
    do_op(4'ha, 1'b1, 32'd7, 32'd7, 0, '{32'h0, 1'b1, 1'b1}, 1);
    do_op(4'he, 1'b0, 32'd3, 32'd4, 0, '{32'd7, 1'b0, 1'b0}, 1);
    do_op(4'he, 1'b1, 32'd3, 32'd4, 0, '{32'd7, 1'b0, 1'b0}, 1);
    do_op(4'h5, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 3, '{32'hAAAAAAAA, 1'b0, 1'b0}, 1);
    do_op(4'h7, 1'b0, 32'hF0000000, 32'd3, 3, '{32'h1E000000, 1'b0, 1'b0}, 4);

    // Abort a long shift: reset sampled on the 10th shift edge.
    bus.inValid = 1'b1;
    bus.aluControl = 4'h2;
    bus.isBranch = 1'b0;
    bus.srcA = 32'h1;
    bus.srcB = 32'd31;
    @(negedge clk);
    bus.inValid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      chk("shift_no_valid", {31'd0, bus.outValid}, 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", {31'd0, bus.inReady}, 32'd1);
    chk("abort_out_valid", {31'd0, bus.outValid}, 32'd0);
    chk("abort_result", bus.aluResult, 32'd0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("abort_stays_idle", {31'd0, bus.outValid}, 32'd0);
    end

    // Abort while a result is waiting in DONE.
    bus.inValid = 1'b1;
    bus.aluControl = 4'h0;
    bus.srcA = 32'd9;
    bus.srcB = 32'd9;
    @(negedge clk);
    bus.inValid = 1'b0;
    chk("done_before_reset", {31'd0, bus.outValid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("done_abort_valid", {31'd0, bus.outValid}, 32'd0);
    chk("done_abort_result", bus.aluResult, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 150; i++) rnd_op($urandom_range(0, 2));

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port inValid  input  1  operation request valid.
REQ-005 SHALL provide port inReady  output  1  block can accept an operation this cycle.
REQ-006 SHALL provide port aluControl  input  4  operation code from the ALU decoder.
REQ-007 SHALL provide port isBranch  input  1  operation is a conditional-branch compare.
REQ-008 SHALL provide port srcA  input  XLEN  first operand.
REQ-009 SHALL provide port srcB  input  XLEN  second operand; srcB[4:0] is the shift amount.
REQ-010 SHALL provide port outValid  output  1  result valid.
REQ-011 SHALL provide port outReady  input  1  consumer accepts result.
REQ-012 SHALL provide port aluResult  output  XLEN  registered result.
REQ-013 SHALL provide port takeBranch  output  1  registered branch decision.
REQ-014 SHALL provide port zero  output  1  registered flag, high when aluResult == 0.

Function
REQ-015 Opcodes SHALL be: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 sra, 7 srl, 8 or, 9 and; with isBranch=1: a beq, b bne, 3 blt, 4 bltu, c bge, d bgeu; e/f and any other unlisted combination SHALL execute add.
REQ-016 Arithmetic SHALL be modulo 2^32; slt/sltu SHALL return 1 or 0 zero-extended; sra SHALL replicate srcA[31].
REQ-017 For isBranch=1, aluResult SHALL be srcA - srcB and takeBranch SHALL be: a eq, b ne, 3 signed lt, 4 unsigned lt, c signed ge, d unsigned ge; takeBranch SHALL be 0 when isBranch=0 or code unlisted.
REQ-018 States SHALL be IDLE, SHIFT, DONE; inReady SHALL be high only in IDLE.
REQ-019 Accept SHALL occur on a rising edge where inValid && inReady; all inputs are sampled only then, later changes ignored.
REQ-020 Non-shift operation or shift with shamt 0: IDLE -> DONE at accept edge; outValid high in the next cycle (latency 1).
REQ-021 Shift (codes 2/6/7, isBranch=0) with shamt n>0: IDLE -> SHIFT at accept; one bit shifted per edge, counter decremented; SHIFT -> DONE on the n-th shift edge; outValid visible n+1 cycles after the accept cycle.
REQ-022 In DONE, outValid SHALL be high and aluResult/takeBranch/zero SHALL hold stable until the edge with outReady=1, then DONE -> IDLE.
REQ-023 inValid while inReady=0 SHALL be ignored (no queueing); inReady SHALL be low for the whole DONE cycle even if outReady=1.
REQ-024 outValid SHALL never be high in IDLE or SHIFT; takeBranch/zero SHALL be valid only with outValid.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, outValid=0, aluResult=0, takeBranch=0, zero=0, shift counter=0, regardless of state.
REQ-026 reset asserted mid-SHIFT or in DONE SHALL abort the operation without ever raising outValid for it; reset has priority over accept.

Verification
REQ-027 add: srcA=0x7FFFFFFF, srcB=1, code 0 -> outValid next cycle, aluResult=0x80000000, zero=0; sub 5-5 -> aluResult=0, zero=1.
REQ-028 sra: srcA=0x80000010, srcB=4, code 6 -> outValid 5 cycles after accept, aluResult=0xF8000001; srl same inputs -> 0x08000001; sll shamt 0 -> srcA, latency 1.
REQ-029 branch: isBranch=1, code c, srcA=0xFFFFFFFF, srcB=1 -> takeBranch=0; code d same operands -> takeBranch=1; code a srcA=srcB=7 -> takeBranch=1, zero=1.
REQ-030 backpressure: complete op with outReady=0 for 3 cycles while inValid=1 and srcA toggles -> outValid, aluResult stable, inReady=0, no second accept; outReady=1 -> IDLE next cycle.
REQ-031 reset mid-shift: sll shamt 31 accepted, reset at 10th shift cycle -> next cycle IDLE, inReady=1, outValid=0, aluResult=0; no outValid for aborted op.
REQ-032 unlisted code e, srcA=3, srcB=4 -> aluResult=7, takeBranch=0.
